// File: rtl/heep_obi_sequencer.sv
// rtl/heep_obi_sequencer.sv - command-driven OBI master that loads/reads X-HEEP memory for the CW305 host
// Optional write read-back verify is enabled by defining HEEP_SEQ_VERIFY_EN.
module heep_obi_sequencer #(
   parameter int pDATA_WIDTH     = 32,
   parameter int pTO_WIDTH       = 10,
   parameter int pTIMEOUT_CYCLES = 1000
) (
   input  logic                   crypto_clk,
   input  logic                   reset_i,
   input  logic                   cmd_valid_i,
   input  logic [1:0]             cmd_op_i,
   input  logic [pDATA_WIDTH-1:0] cmd_data_i,
   output logic                   cmd_ready_o,
   input  logic                   clear_err_i,
   output logic                   obi_req_o,
   output logic                   obi_we_o,
   output logic [3:0]             obi_be_o,
   output logic [pDATA_WIDTH-1:0] obi_addr_o,
   output logic [pDATA_WIDTH-1:0] obi_wdata_o,
   input  logic                   obi_gnt_i,
   input  logic                   obi_rvalid_i,
   input  logic [pDATA_WIDTH-1:0] obi_rdata_i,
   output logic [pDATA_WIDTH-1:0] rdata_o,
   output logic [pDATA_WIDTH-1:0] cur_addr_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [3:0]             err_o
);

   localparam logic [1:0] OP_SET_ADDR = 2'd0;
   localparam logic [1:0] OP_WRITE    = 2'd1;
   localparam logic [1:0] OP_READ     = 2'd2;
   localparam logic [pTO_WIDTH-1:0] TO_LAST = pTO_WIDTH'(pTIMEOUT_CYCLES - 1);

`ifdef HEEP_SEQ_VERIFY_EN
   typedef enum logic [2:0] {IDLE, REQ, RESP, VREQ, VRESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
`endif

   state_t                 state, state_nxt;
   logic [pTO_WIDTH-1:0]   to_cnt, to_cnt_nxt;
   logic                   req_nxt, we_nxt, busy_nxt, done_nxt, ready_nxt;
   logic [3:0]             be_nxt, err_set, err_nxt;
   logic [pDATA_WIDTH-1:0] addr_nxt, wdata_nxt, rdata_nxt, cur_addr_nxt;
   logic                   to_hit;

   assign to_hit = (to_cnt == TO_LAST);

   always_ff @(posedge crypto_clk or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         to_cnt      <= '0;
         obi_req_o   <= 1'b0;
         obi_we_o    <= 1'b0;
         obi_be_o    <= 4'h0;
         obi_addr_o  <= '0;
         obi_wdata_o <= '0;
         rdata_o     <= '0;
         cur_addr_o  <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 4'h0;
         cmd_ready_o <= 1'b1;
      end else begin
         state       <= state_nxt;
         to_cnt      <= to_cnt_nxt;
         obi_req_o   <= req_nxt;
         obi_we_o    <= we_nxt;
         obi_be_o    <= be_nxt;
         obi_addr_o  <= addr_nxt;
         obi_wdata_o <= wdata_nxt;
         rdata_o     <= rdata_nxt;
         cur_addr_o  <= cur_addr_nxt;
         busy_o      <= busy_nxt;
         done_o      <= done_nxt;
         err_o       <= err_nxt;
         cmd_ready_o <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      to_cnt_nxt   = to_cnt;
      req_nxt      = obi_req_o;
      we_nxt       = obi_we_o;
      addr_nxt     = obi_addr_o;
      wdata_nxt    = obi_wdata_o;
      rdata_nxt    = rdata_o;
      cur_addr_nxt = cur_addr_o;
      done_nxt     = 1'b0;
      err_set      = 4'h0;

      // Any strobe outside IDLE is a host protocol violation and is dropped.
      if (cmd_valid_i && state != IDLE) err_set[2] = 1'b1;

      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               case (cmd_op_i)
                  OP_SET_ADDR: begin
                     if (cmd_data_i[1:0] == 2'b00) cur_addr_nxt = cmd_data_i;
                     else                          err_set[1]   = 1'b1;
                     done_nxt = 1'b1;
                  end
                  OP_WRITE, OP_READ: begin
                     state_nxt  = REQ;
                     req_nxt    = 1'b1;
                     we_nxt     = (cmd_op_i == OP_WRITE);
                     addr_nxt   = cur_addr_o;
                     wdata_nxt  = cmd_data_i;
                     to_cnt_nxt = '0;
                  end
                  default: begin
                     err_set[2] = 1'b1;
                     done_nxt   = 1'b1;
                  end
               endcase
            end
         end
         REQ: begin
            if (obi_gnt_i) begin
               state_nxt    = RESP;
               req_nxt      = 1'b0;
               cur_addr_nxt = cur_addr_o + pDATA_WIDTH'(4);
               to_cnt_nxt   = '0;
            end else if (to_hit) begin
               state_nxt  = IDLE;
               req_nxt    = 1'b0;
               err_set[0] = 1'b1;
               to_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         RESP: begin
            if (obi_rvalid_i) begin
               to_cnt_nxt = '0;
               if (!obi_we_o) rdata_nxt = obi_rdata_i;
`ifdef HEEP_SEQ_VERIFY_EN
               if (obi_we_o) begin
                  // Read back the address just written; obi_addr_o still holds it.
                  state_nxt = VREQ;
                  req_nxt   = 1'b1;
                  we_nxt    = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
`else
               state_nxt = IDLE;
               done_nxt  = 1'b1;
`endif
            end else if (to_hit) begin
               state_nxt  = IDLE;
               err_set[0] = 1'b1;
               to_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
`ifdef HEEP_SEQ_VERIFY_EN
         VREQ: begin
            if (obi_gnt_i) begin
               state_nxt  = VRESP;
               req_nxt    = 1'b0;
               to_cnt_nxt = '0;
            end else if (to_hit) begin
               state_nxt  = IDLE;
               req_nxt    = 1'b0;
               err_set[0] = 1'b1;
               to_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         VRESP: begin
            if (obi_rvalid_i) begin
               rdata_nxt  = obi_rdata_i;
               err_set[3] = (obi_rdata_i != obi_wdata_o);
               state_nxt  = IDLE;
               done_nxt   = 1'b1;
               to_cnt_nxt = '0;
            end else if (to_hit) begin
               state_nxt  = IDLE;
               err_set[0] = 1'b1;
               to_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
         end
      endcase

      // A new error in the same cycle as a clear survives the clear.
      err_nxt   = (clear_err_i ? 4'h0 : err_o) | err_set;
      be_nxt    = req_nxt ? 4'hF : 4'h0;
      busy_nxt  = (state_nxt != IDLE);
      ready_nxt = (state_nxt == IDLE);
   end

endmodule

// File: tb/tb_heep_obi_sequencer.sv
// tb/tb_heep_obi_sequencer.sv - table-driven bench for heep_obi_sequencer with a small OBI slave
module tb_heep_obi_sequencer;

   logic        crypto_clk = 1'b0;
   logic        reset_i    = 1'b1;
   logic        cmd_valid  = 1'b0;
   logic [1:0]  cmd_op     = 2'd0;
   logic [31:0] cmd_data   = 32'h0;
   logic        cmd_ready;
   logic        clear_err  = 1'b0;
   logic        obi_req, obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_addr, obi_wdata;
   logic        obi_gnt    = 1'b0;
   logic        obi_rvalid = 1'b0;
   logic [31:0] obi_rdata  = 32'h0;
   logic [31:0] rdata, cur_addr;
   logic        busy, done;
   logic [3:0]  err;

   int nvec = 0;
   int nerr = 0;

`ifdef HEEP_SEQ_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif
   localparam int VX = VER ? 2 : 0;

   always #5 crypto_clk = ~crypto_clk;

   heep_obi_sequencer dut (
      .crypto_clk   (crypto_clk),
      .reset_i      (reset_i),
      .cmd_valid_i  (cmd_valid),
      .cmd_op_i     (cmd_op),
      .cmd_data_i   (cmd_data),
      .cmd_ready_o  (cmd_ready),
      .clear_err_i  (clear_err),
      .obi_req_o    (obi_req),
      .obi_we_o     (obi_we),
      .obi_be_o     (obi_be),
      .obi_addr_o   (obi_addr),
      .obi_wdata_o  (obi_wdata),
      .obi_gnt_i    (obi_gnt),
      .obi_rvalid_i (obi_rvalid),
      .obi_rdata_i  (obi_rdata),
      .rdata_o      (rdata),
      .cur_addr_o   (cur_addr),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic        clr;
      int          gdly;
      int          rdly;
      logic [31:0] rd;
      logic [31:0] vd;
      int          exp_done;
      logic [31:0] exp_cur;
      logic [3:0]  exp_err;
      logic [31:0] exp_rdata;
      int          exp_nreq;
      logic [31:0] exp_addr0;
      logic        exp_we0;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic step();
      @(posedge crypto_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] op, input logic [31:0] data, input logic clr,
                      input int gdly, input int rdly, input logic [31:0] rd, input logic [31:0] vd,
                      input int edone, input logic [31:0] ecur, input logic [3:0] eerr,
                      input logic [31:0] erd, input int enreq, input logic [31:0] ea0,
                      input logic ewe0, input logic ebusy);
      vec_t v;
      v.op = op; v.data = data; v.clr = clr; v.gdly = gdly; v.rdly = rdly; v.rd = rd; v.vd = vd;
      v.exp_done = edone; v.exp_cur = ecur; v.exp_err = eerr; v.exp_rdata = erd;
      v.exp_nreq = enreq; v.exp_addr0 = ea0; v.exp_we0 = ewe0; v.exp_busy = ebusy;
      vecs.push_back(v);
   endtask

   // Drive one command and act as the OBI slave until done_o or a cycle budget runs out.
   task automatic run_vec(input vec_t v, input int idx);
      int          c, done_cyc, nreq, wcnt, rv_wait;
      bit          in_req, rv_pend, busy_any, stable;
      logic [31:0] a0, a1, a_cur, d_cur;
      logic        we0, we1, w_cur;
      string       tag;
      a0 = 0; a1 = 0; we0 = 0; we1 = 0; a_cur = 0; d_cur = 0; w_cur = 0;
      cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; clear_err = v.clr;
      step();
      cmd_valid = 1'b0; clear_err = 1'b0;
      c = 1; done_cyc = -1; nreq = 0; wcnt = 0; rv_wait = 0;
      in_req = 0; rv_pend = 0; busy_any = 0; stable = 1;
      while (done_cyc < 0 && c < 64) begin
         obi_gnt = 1'b0; obi_rvalid = 1'b0;
         if (busy) busy_any = 1;
         if (done) begin
            done_cyc = c;
         end else begin
            if (obi_req) begin
               if (!in_req) begin
                  in_req = 1; wcnt = 0; nreq++;
                  a_cur = obi_addr; w_cur = obi_we; d_cur = obi_wdata;
                  if (nreq == 1) begin a0 = obi_addr; we0 = obi_we; end
                  else begin a1 = obi_addr; we1 = obi_we; end
               end else if (obi_addr !== a_cur || obi_we !== w_cur || obi_wdata !== d_cur) begin
                  stable = 0;
               end
               if (obi_be !== 4'hF) stable = 0;
               if (wcnt == v.gdly) begin
                  obi_gnt = 1'b1; in_req = 0; rv_pend = 1; rv_wait = 0;
               end else begin
                  wcnt++;
               end
            end else if (rv_pend) begin
               if (rv_wait == v.rdly) begin
                  obi_rvalid = 1'b1; rv_pend = 0;
                  obi_rdata  = (nreq >= 2) ? v.vd : v.rd;
               end else begin
                  rv_wait++;
               end
            end
            step();
            c++;
         end
      end
      obi_gnt = 1'b0; obi_rvalid = 1'b0;
      tag = $sformatf("v%0d", idx);
      chk({tag, " done_cycle"}, done_cyc, v.exp_done);
      chk({tag, " cur_addr"}, cur_addr, v.exp_cur);
      chk({tag, " err"}, {28'h0, err}, {28'h0, v.exp_err});
      chk({tag, " rdata"}, rdata, v.exp_rdata);
      chk({tag, " nreq"}, nreq, v.exp_nreq);
      chk({tag, " busy_seen"}, {31'h0, busy_any}, {31'h0, v.exp_busy});
      chk({tag, " ready_at_done"}, {31'h0, cmd_ready}, 32'h1);
      chk({tag, " req_stable"}, {31'h0, stable}, 32'h1);
      if (nreq > 0) begin
         chk({tag, " addr0"}, a0, v.exp_addr0);
         chk({tag, " we0"}, {31'h0, we0}, {31'h0, v.exp_we0});
      end
      if (nreq > 1) begin
         chk({tag, " verify_addr"}, a1, v.exp_addr0);
         chk({tag, " verify_we"}, {31'h0, we1}, 32'h0);
      end
      step();
   endtask

   initial begin : main
      bit          done_seen;
      logic [31:0] r7, rlast;
      r7    = VER ? 32'h0BADF00D : 32'hA5A50001;
      rlast = VER ? 32'hDEADBEEE : r7;

      add(2'd0, 32'h00000100, 0, 0, 0, 0, 0, 1, 32'h100, 4'h0, 32'h0, 0, 0, 0, 0);
      add(2'd1, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 3 + VX, 32'h104, 4'h0,
          VER ? 32'hDEADBEEF : 32'h0, 1 + int'(VER), 32'h100, 1, 1);
      add(2'd2, 32'h0, 0, 3, 0, 32'h12345678, 0, 6, 32'h108, 4'h0, 32'h12345678, 1, 32'h104, 0, 1);
      add(2'd2, 32'h0, 0, 0, 2, 32'hA5A50001, 0, 5, 32'h10C, 4'h0, 32'hA5A50001, 1, 32'h108, 0, 1);
      add(2'd0, 32'h00000102, 0, 0, 0, 0, 0, 1, 32'h10C, 4'b0010, 32'hA5A50001, 0, 0, 0, 0);
      add(2'd0, 32'hFFFFFFFC, 1, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 4'h0, 32'hA5A50001, 0, 0, 0, 0);
      add(2'd1, 32'h0BADF00D, 0, 0, 0, 0, 32'h0BADF00D, 3 + VX, 32'h0, 4'h0, r7,
          1 + int'(VER), 32'hFFFFFFFC, 1, 1);
      add(2'd3, 32'h00005555, 0, 0, 0, 0, 0, 1, 32'h0, 4'b0100, r7, 0, 0, 0, 0);
      add(2'd0, 32'h00000003, 1, 0, 0, 0, 0, 1, 32'h0, 4'b0010, r7, 0, 0, 0, 0);
`ifdef HEEP_SEQ_VERIFY_EN
      add(2'd0, 32'h00000040, 1, 0, 0, 0, 0, 1, 32'h40, 4'h0, r7, 0, 0, 0, 0);
      add(2'd1, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEE, 5, 32'h44, 4'b1000, 32'hDEADBEEE,
          2, 32'h40, 1, 1);
`endif
      add(2'd0, 32'h00000200, 1, 0, 0, 0, 0, 1, 32'h200, 4'h0, rlast, 0, 0, 0, 0);

      repeat (3) step();
      chk("reset ready", {31'h0, cmd_ready}, 32'h1);
      chk("reset req", {31'h0, obi_req}, 32'h0);
      chk("reset be", {28'h0, obi_be}, 32'h0);
      chk("reset busy_done", {30'h0, busy, done}, 32'h0);
      chk("reset cur_addr", cur_addr, 32'h0);
      chk("reset err", {28'h0, err}, 32'h0);
      reset_i = 1'b0;
      step();
      chk("post-reset ready", {31'h0, cmd_ready}, 32'h1);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // REQ timeout with a strobe dropped mid-transaction.
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'h0;
      step();
      done_seen = 0;
      for (int c = 1; c <= 1003; c++) begin
         if (done) done_seen = 1;
         cmd_valid = (c == 5);
         cmd_op    = 2'd0;
         cmd_data  = 32'h4;
         if (c == 6) begin
            chk("midstrobe err", {28'h0, err}, 32'h4);
            chk("midstrobe req", {31'h0, obi_req}, 32'h1);
         end
         if (c == 1000) chk("to req_last", {31'h0, obi_req}, 32'h1);
         if (c == 1001) begin
            chk("to req_drop", {31'h0, obi_req}, 32'h0);
            chk("to err", {28'h0, err}, 32'h5);
         end
         step();
      end
      cmd_valid = 1'b0;
      chk("to no_done", {31'h0, done_seen}, 32'h0);
      chk("to cur_addr", cur_addr, 32'h200);
      chk("to idle", {30'h0, busy, cmd_ready}, 32'h1);
      obi_rvalid = 1'b1; obi_rdata = 32'hFFFFFFFF;
      step();
      obi_rvalid = 1'b0;
      step();
      chk("late rvalid rdata", rdata, rlast);
      chk("late rvalid done", {31'h0, done}, 32'h0);

      // RESP timeout: grant seen, so the address still advances.
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("clear err", {28'h0, err}, 32'h0);
      cmd_valid = 1'b1; cmd_op = 2'd2;
      step();
      cmd_valid = 1'b0;
      done_seen = 0;
      for (int c = 1; c <= 1003; c++) begin
         if (done) done_seen = 1;
         obi_gnt = (c == 1);
         if (c == 1001) chk("rto busy_last", {31'h0, busy}, 32'h1);
         if (c == 1002) begin
            chk("rto busy_drop", {31'h0, busy}, 32'h0);
            chk("rto err", {28'h0, err}, 32'h1);
         end
         step();
      end
      obi_gnt = 1'b0;
      chk("rto no_done", {31'h0, done_seen}, 32'h0);
      chk("rto cur_addr", cur_addr, 32'h204);

      // Asynchronous reset in the middle of a request.
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 32'h11112222;
      step();
      cmd_valid = 1'b0;
      chk("pre-reset req", {31'h0, obi_req}, 32'h1);
      #2 reset_i = 1'b1;
      #1;
      chk("async reset req", {31'h0, obi_req}, 32'h0);
      chk("async reset ready", {31'h0, cmd_ready}, 32'h1);
      chk("async reset cur_addr", cur_addr, 32'h0);
      chk("async reset err", {28'h0, err}, 32'h0);
      step();
      reset_i = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
